gsa_frame_packer: RTL and testbench
===================================

Name: gsa_frame_packer

Overview:
Downstream stage of growing_avg_signed. Captures each averaged sample (y qualified by new_dat) into a small FIFO and emits fixed-length frames on a valid/ready stream. Each frame is one header word (averaging setting and sequence number) followed by FRAME_LEN sample words. This feeds the readout/DMA path and decouples the averager from readout backpressure.

Parameters:
N, 16, sample width in bits; must be >= 16 so the header fits.
FRAME_LEN, 8, sample words per frame, not counting the header.
DEPTH, 16, FIFO depth in words; power of 2; must be >= FRAME_LEN.

Ports:
clk  in  1  system clock, single domain.
rst  in  1  synchronous, active-high reset.
new_dat  in  1  one-cycle strobe from the averager: y holds a new average.
y  in  N  averaged sample, signed two's complement; passed through bit-exact.
n_avgs  in  8  averaging setting currently applied to the averager (N_AVGS_in).
m_data  out  N  stream data.
m_valid  out  1  stream valid.
m_ready  in  1  stream ready from the consumer.
m_last  out  1  high on the final sample beat of a frame.
overflow  out  1  sticky flag: a sample was dropped.
clr_overflow  in  1  clears overflow; set has priority when both occur in the same cycle.

Behaviour:
- Reset values: m_valid=0, m_last=0, m_data=0, overflow=0, FIFO empty, seq=0, state IDLE, flush_pend=0.
- Write side: when new_dat=1 and count<DEPTH, push y. Full is judged on the registered count, so a pop in the same cycle does not free space. If new_dat=1 and count==DEPTH, drop the sample and set overflow.
- Push and pop in the same cycle leave count unchanged.
- Header word: m_data[N-1:8] = {zero-extend, n_avgs latched on IDLE->HEADER}; m_data[7:0] = seq.
- FSM, IDLE: m_valid=0. Go to HEADER when count>=FRAME_LEN and flush_pend=0.
- Latency: the FRAME_LEN-th sample pushed at edge k gives m_valid=1 after edge k+1.
- FSM, HEADER: present the header. On m_valid&m_ready go to BODY and clear beat_cnt.
- FSM, BODY: m_data = FIFO head. Each handshake pops one word and increments beat_cnt.
- m_last=1 while beat_cnt==FRAME_LEN-1. The handshake on that beat increments seq (mod 256) and returns to IDLE.
- BODY never starves: a whole frame was resident before HEADER was entered.
- Stream rule: once m_valid=1, m_data and m_last hold until the handshake; m_valid never drops without a handshake (except on rst).
- Setting change: n_avgs differing from its registered copy sets flush_pend.
  - In IDLE, flush immediately (next cycle): pointers and count to 0, flush_pend cleared.
  - In HEADER/BODY, the current frame completes with its latched tag; the flush executes on entry to IDLE.
  - Samples pushed while flush is pending are discarded by the flush.
- Reset mid-frame: the frame is abandoned with no m_last; m_valid=0 after the rst edge. seq restarts at 0.
- No arithmetic on sample data. Counters: count needs log2(DEPTH)+1 bits, beat_cnt needs log2(FRAME_LEN) bits, seq is 8 bits.

Decomposition:
- gsa_pkg holds:
  - state enum {IDLE, HEADER, BODY};
  - header field offsets (TAG_LSB=8, SEQ_W=8).
- One sub-module: gsa_sync_fifo.
  - Parameters WIDTH, DEPTH; ports clk, rst, flush, push, din, pop, dout (first-word fall-through), count.
  - The packer holds the FSM, header mux, overflow and flush logic.

Test Plan:
- Basic frame: rst, n_avgs=3, m_ready=1, 8 new_dat strobes y=1..8 -> 9 consecutive beats: 0x0300, then 1..8; m_last only on 8; next header is 0x0301.
- Backpressure: same stimulus with m_ready alternating 1/0 -> identical beat sequence; m_data/m_last stable during every stalled cycle.
- Overflow: m_ready=0, 20 strobes y=1..20 -> overflow=1 from the 17th strobe. Releasing m_ready gives frames seq0 {1..8} and seq1 {9..16}, and 17..20 never appear. clr_overflow then returns overflow to 0.
- Full with simultaneous pop: count=16, m_ready=1 in BODY, new_dat=1 in the same cycle -> sample dropped, overflow=1, count becomes 15.
- Setting change mid-frame: switch n_avgs 3->4 after 3 body beats -> frame completes with tag 3 and all 8 samples; FIFO empty on IDLE; next header is 0x04xx built only from post-flush samples.
- Reset/sign: assert rst after 4 body beats -> m_valid=0 next cycle; next frame header seq=0. A sample y=16'h8000 appears unchanged on m_data.

Source files
------------

// File: rtl/gsa_pkg.sv
// Shared types and header layout for the growing_avg_signed frame packer.
package gsa_pkg;

  // Packer output state: waiting for a full frame, presenting the header,
  // or streaming the frame's sample words.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } state_t;

  // Header word layout: {zero-extend, n_avgs tag, sequence number}.
  localparam int TAG_LSB = 8;
  localparam int TAG_W   = 8;
  localparam int SEQ_W   = 8;

endpackage

// File: rtl/gsa_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a synchronous flush.
// dout always shows the oldest resident word; it is meaningless when empty.
module gsa_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty are judged on the registered count only, so a pop in the
  // same cycle never makes room for a push.
  assign push_ok = push && (count_reg < DEPTH_C);
  assign pop_ok  = pop && (count_reg != '0);

  // Storage write; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/gsa_frame_packer.sv
// Packs averaged samples into frames of one header word plus FRAME_LEN
// sample words on a valid/ready stream, buffering through a small FIFO so
// the averager never waits on readout backpressure.
module gsa_frame_packer
  import gsa_pkg::*;
#(
  parameter int N         = 16,
  parameter int FRAME_LEN = 8,
  parameter int DEPTH     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_dat,
  input  logic [N-1:0] y,
  input  logic [7:0]   n_avgs,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         overflow,
  input  logic         clr_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(FRAME_LEN - 1);

  state_t             state_reg;
  logic [BW-1:0]      beat_reg;
  logic [SEQ_W-1:0]   seq_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [7:0]         n_avgs_reg;
  logic               flush_pend_reg;
  logic               overflow_reg;
  logic               m_valid_reg;
  logic               m_last_reg;

  logic [CW-1:0]      fifo_count;
  logic [N-1:0]       fifo_dout;
  logic               push;
  logic               pop;
  logic               drop;
  logic               handshake;
  logic               last_handshake;
  logic               setting_change;
  logic               flush_now;
  logic [BW-1:0]      beat_inc;
  logic [N-1:0]       header_word;

  assign handshake      = m_valid_reg && m_ready;
  assign last_handshake = handshake && (state_reg == BODY) && m_last_reg;
  assign push           = new_dat && (fifo_count < DEPTH_C);
  assign drop           = new_dat && (fifo_count == DEPTH_C);
  assign pop            = handshake && (state_reg == BODY);
  assign setting_change = (n_avgs != n_avgs_reg);
  // A pending flush runs while idle, or on the very edge that closes the
  // current frame so the FIFO is already empty when IDLE is entered.
  assign flush_now      = flush_pend_reg && ((state_reg == IDLE) || last_handshake);
  assign beat_inc       = beat_reg + 1'b1;

  gsa_sync_fifo #(
    .WIDTH (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_now),
    .push  (push),
    .din   (y),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Track the averaging setting and remember that a flush is owed.
  always_ff @(posedge clk) begin
    n_avgs_reg <= n_avgs;
    if (rst) begin
      flush_pend_reg <= 1'b0;
    end else if (setting_change) begin
      flush_pend_reg <= 1'b1;
    end else if (flush_now) begin
      flush_pend_reg <= 1'b0;
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clr_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  // Frame sequencer with registered valid/last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      seq_reg     <= '0;
      tag_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Only start once a whole frame is resident so BODY never starves;
          // hold off while a setting change is in flight.
          if ((fifo_count >= FRAME_LEN_C) && !flush_pend_reg && !setting_change) begin
            state_reg   <= HEADER;
            tag_reg     <= n_avgs_reg;
            m_valid_reg <= 1'b1;
          end
        end
        HEADER: begin
          if (handshake) begin
            state_reg  <= BODY;
            beat_reg   <= '0;
            m_last_reg <= (LAST_BEAT == '0);
          end
        end
        BODY: begin
          if (handshake) begin
            if (m_last_reg) begin
              state_reg   <= IDLE;
              m_valid_reg <= 1'b0;
              m_last_reg  <= 1'b0;
              seq_reg     <= seq_reg + 1'b1;
            end else begin
              beat_reg   <= beat_inc;
              m_last_reg <= (beat_inc == LAST_BEAT);
            end
          end
        end
        default: begin
          state_reg   <= IDLE;
          m_valid_reg <= 1'b0;
          m_last_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Header word assembled from registered fields only, so it is stable
  // for as long as HEADER is held.
  always_comb begin
    header_word                      = '0;
    header_word[TAG_LSB +: TAG_W]    = tag_reg;
    header_word[SEQ_W-1:0]           = seq_reg;
  end

  // Output data select: header, FIFO head, or zero while idle.
  always_comb begin
    m_data = '0;
    if (state_reg == HEADER) begin
      m_data = header_word;
    end else if (state_reg == BODY) begin
      m_data = fifo_dout;
    end
  end

  assign m_valid  = m_valid_reg;
  assign m_last   = m_last_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_gsa_frame_packer.sv
// Self-checking bench for gsa_frame_packer: expected beats are queued as
// samples are strobed and compared as the stream hands them off.
module tb_gsa_frame_packer;

  localparam int N         = 16;
  localparam int FRAME_LEN = 8;
  localparam int DEPTH     = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         new_dat = 1'b0;
  logic [N-1:0] y = '0;
  logic [7:0]   n_avgs = 8'd3;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic         overflow;
  logic         clr_overflow = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [N:0] exp_q [$];

  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic         prev_rst   = 1'b1;
  logic [N-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;

  gsa_frame_packer #(
    .N         (N),
    .FRAME_LEN (FRAME_LEN),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .new_dat      (new_dat),
    .y            (y),
    .n_avgs       (n_avgs),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // Stream monitor: inputs change 1 ns after posedge, so the values seen at
  // negedge are exactly what the next posedge acts on.
  always @(negedge clk) begin
    logic [N:0] e;
    if (!rst && prev_valid && !prev_ready && !prev_rst) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                 m_valid, m_data, m_last, prev_data, prev_last);
      end
    end
    if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h last=%b, want no beat", m_data, m_last);
      end else begin
        e = exp_q.pop_front();
        if ({m_last, m_data} !== e) begin
          errors++;
          $display("FAIL beat: got data=%h last=%b, want data=%h last=%b",
                   m_data, m_last, e[N-1:0], e[N]);
        end else begin
          $display("beat data=%h last=%b", m_data, m_last);
        end
      end
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_rst   = rst;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [N-1:0] v);
    new_dat = 1'b1;
    y       = v;
    step();
    new_dat = 1'b0;
  endtask

  task automatic push_header(input logic [7:0] tag, input logic [7:0] seq);
    exp_q.push_back({1'b0, tag, seq});
  endtask

  task automatic push_sample(input logic [N-1:0] v, input logic last);
    exp_q.push_back({last, v});
  endtask

  task automatic do_reset(input logic [7:0] setting);
    rst          = 1'b1;
    n_avgs       = setting;
    m_ready      = 1'b0;
    new_dat      = 1'b0;
    clr_overflow = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      step();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats outstanding, want 0", exp_q.size());
    end
    step();
    step();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_drain: got m_valid=%b, want 0", m_valid);
    end
  endtask

  task automatic test_reset();
    do_reset(8'd3);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b last=%b data=%h ovf=%b, want 0 0 0000 0",
               m_valid, m_last, m_data, overflow);
    end
  endtask

  task automatic test_basic();
    do_reset(8'd3);
    m_ready = 1'b1;
    push_header(8'd3, 8'd0);
    for (int i = 1; i <= FRAME_LEN; i++) begin
      push_sample(N'(i), i == FRAME_LEN);
      strobe(N'(i));
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got m_valid=%b, want 0", m_valid);
    end
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h0300) begin
      errors++;
      $display("FAIL latency_header: got valid=%b data=%h, want valid=1 data=0300", m_valid, m_data);
    end
    wait_drain();
    push_header(8'd3, 8'd1);
    for (int i = 9; i <= 16; i++) begin
      push_sample(N'(i), i == 16);
      strobe(N'(i));
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    do_reset(8'd3);
    fork
      begin
        push_header(8'd3, 8'd0);
        for (int i = 1; i <= FRAME_LEN; i++) begin
          push_sample(N'(i), i == FRAME_LEN);
          strobe(N'(i));
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          m_ready = ~m_ready;
          step();
        end
      end
    join
    m_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_overflow();
    do_reset(8'd3);
    for (int i = 1; i <= 20; i++) begin
      if (i == 1) push_header(8'd3, 8'd0);
      if (i == 9) push_header(8'd3, 8'd1);
      if (i <= 16) push_sample(N'(i), (i == 8) || (i == 16));
      strobe(N'(i));
      if (i == 16) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_before_full: got %b, want 0", overflow);
        end
      end
      if (i == 17) begin
        checks++;
        if (overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_on_17th: got %b, want 1", overflow);
        end
      end
    end
    m_ready = 1'b1;
    wait_drain();
    repeat (20) step();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, want 1", overflow);
    end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b, want 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset(8'd3);
    push_header(8'd3, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      push_sample(N'(i), i == 8);
      strobe(N'(i));
    end
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    push_header(8'd3, 8'd1);
    for (int i = 9; i <= 16; i++) begin
      push_sample(N'(i), i == 16);
      strobe(N'(i));
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_no_ovf: got %b, want 0", overflow);
    end
    // Full FIFO, body pop and a new sample on the same edge: sample is lost.
    m_ready = 1'b1;
    strobe(16'd99);
    m_ready = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_drop: got %b, want 1", overflow);
    end
    push_header(8'd3, 8'd2);
    push_sample(16'd17, 1'b0);
    strobe(16'd17);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_space: got %b, want 0 (17 must have fit)", overflow);
    end
    clr_overflow = 1'b1;
    strobe(16'd18);
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_priority: got %b, want 1", overflow);
    end
    m_ready = 1'b1;
    step();
    for (int i = 19; i <= 25; i++) begin
      push_sample(N'(i), i == 25);
      strobe(N'(i));
    end
    wait_drain();
  endtask

  task automatic test_setting_change();
    do_reset(8'd3);
    push_header(8'd3, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      push_sample(N'(i), i == 8);
      strobe(N'(i));
    end
    step();
    m_ready = 1'b1;
    repeat (4) step();
    n_avgs = 8'd4;
    strobe(16'd9);
    strobe(16'd10);
    wait_drain();
    push_header(8'd4, 8'd1);
    for (int i = 21; i <= 27; i++) begin
      push_sample(N'(i), 1'b0);
      strobe(N'(i));
    end
    repeat (3) step();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: got m_valid=%b, want 0 with 7 samples", m_valid);
    end
    push_sample(16'd28, 1'b1);
    strobe(16'd28);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    do_reset(8'd3);
    push_header(8'd3, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      push_sample(N'(i), i == 8);
      strobe(N'(i));
    end
    step();
    m_ready = 1'b1;
    repeat (5) step();
    m_ready = 1'b0;
    rst     = 1'b1;
    step();
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b last=%b, want 0 0", m_valid, m_last);
    end
    rst = 1'b0;
    exp_q.delete();
    push_header(8'd3, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      logic [N-1:0] v;
      v = (i == 1) ? 16'h8000 : N'(i);
      push_sample(v, i == 8);
      strobe(v);
    end
    m_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_setting_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
